// File: rtl/board_pkg.sv
// Shared definitions for the iCE40 board tops: sequencer states, SB_IO pin
// types and warmboot image width.
package board_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_RAIL_DOWN,
        ST_SETTLE,
        ST_ARM,
        ST_BOOT
    } seq_state_t;

    // SB_IO PIN_TYPE encodings used by the board tops for user pads.
    localparam logic [5:0] IOB_PIN_INPUT    = 6'b000001;
    localparam logic [5:0] IOB_PIN_OUTPUT   = 6'b011001;
    localparam logic [5:0] IOB_PIN_TRISTATE = 6'b101001;

    localparam int WB_IMAGE_W = 2;
    localparam int ARM_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// It holds at zero rather than wrapping, so an idle timer stays done.
module step_timer #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_48mhz,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RESET_VALUE;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/warmboot_sequencer.sv
// Staged rail power-up, then on request: reverse rail power-down, settle,
// and drive SB_WARMBOOT select/boot to launch the chosen image.
module warmboot_sequencer
    import board_pkg::*;
#(
    parameter int                   NUM_RAILS     = 2,
    parameter logic [NUM_RAILS-1:0] RAIL_INIT_ON  = {NUM_RAILS{1'b1}},
    parameter int                   RAIL_STEP     = 48000,
    parameter int                   SETTLE_CYCLES = 480000,
    parameter int                   NUM_IMAGES    = 4
) (
    input  logic                  clk_48mhz,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_image,
    input  logic                  abort,
    output logic [NUM_RAILS-1:0]  rail_en,
    output logic                  pads_release,
    output logic [1:0]            wb_s,
    output logic                  wb_boot,
    output logic                  busy,
    output logic                  bad_image
);

    localparam int TIMER_W    = $clog2(max_int(RAIL_STEP, SETTLE_CYCLES) + 1);
    localparam int RAIL_IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

    localparam logic [TIMER_W-1:0]    RAIL_STEP_M1 = TIMER_W'(RAIL_STEP - 1);
    localparam logic [TIMER_W-1:0]    SETTLE_M1    = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    ARM_M1       = TIMER_W'(ARM_CYCLES - 1);
    localparam logic [RAIL_IDX_W-1:0] LAST_RAIL    = RAIL_IDX_W'(NUM_RAILS - 1);
    localparam logic [2:0]            NUM_IMAGES_L = 3'(NUM_IMAGES);

    seq_state_t state_q, state_d;

    logic [RAIL_IDX_W-1:0] rail_idx_q, rail_idx_d;
    logic [WB_IMAGE_W-1:0] image_q, image_d;
    logic [NUM_RAILS-1:0]  rail_en_q, rail_en_d;
    logic                  pads_release_q, pads_release_d;
    logic [WB_IMAGE_W-1:0] wb_s_q, wb_s_d;
    logic                  wb_boot_q, wb_boot_d;
    logic                  busy_q, busy_d;
    logic                  req_ready_q, req_ready_d;
    logic                  bad_image_q, bad_image_d;

    logic                  timer_load;
    logic [TIMER_W-1:0]    timer_value;
    logic                  timer_done;

    logic accept;
    logic abort_hit;
    logic image_oor;

    assign accept    = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign abort_hit = abort && ((state_q == ST_RAIL_DOWN) || (state_q == ST_SETTLE));
    assign image_oor = ({1'b0, req_image} >= NUM_IMAGES_L);

    step_timer #(
        .WIDTH       (TIMER_W),
        .RESET_VALUE (RAIL_STEP_M1)
    ) u_step_timer (
        .clk_48mhz  (clk_48mhz),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_PWRUP;
            rail_idx_q     <= '0;
            image_q        <= '0;
            rail_en_q      <= '0;
            pads_release_q <= 1'b1;
            wb_s_q         <= '0;
            wb_boot_q      <= 1'b0;
            busy_q         <= 1'b1;
            req_ready_q    <= 1'b0;
            bad_image_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rail_idx_q     <= rail_idx_d;
            image_q        <= image_d;
            rail_en_q      <= rail_en_d;
            pads_release_q <= pads_release_d;
            wb_s_q         <= wb_s_d;
            wb_boot_q      <= wb_boot_d;
            busy_q         <= busy_d;
            req_ready_q    <= req_ready_d;
            bad_image_q    <= bad_image_d;
        end
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        rail_idx_d  = rail_idx_q;
        image_d     = image_q;
        timer_load  = 1'b0;
        timer_value = RAIL_STEP_M1;
        unique case (state_q)
            ST_PWRUP: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    if (rail_idx_q == LAST_RAIL) begin
                        state_d = ST_IDLE;
                    end else begin
                        rail_idx_d = rail_idx_q + RAIL_IDX_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_RAIL_DOWN;
                    rail_idx_d = LAST_RAIL;
                    image_d    = image_oor ? '0 : req_image;
                    timer_load = 1'b1;
                end
            end
            ST_RAIL_DOWN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (timer_done) begin
                    timer_load = 1'b1;
                    if (rail_idx_q == '0) begin
                        state_d     = ST_SETTLE;
                        timer_value = SETTLE_M1;
                    end else begin
                        rail_idx_d = rail_idx_q - RAIL_IDX_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (timer_done) begin
                    state_d     = ST_ARM;
                    timer_load  = 1'b1;
                    timer_value = ARM_M1;
                end
            end
            ST_ARM: begin
                if (timer_done) begin
                    state_d = ST_BOOT;
                end
            end
            ST_BOOT: begin
                state_d = ST_BOOT;
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase
    end

    // Output registers are loaded from the next state so every pin is a flop.
    always_comb begin
        rail_en_d   = rail_en_q;
        bad_image_d = bad_image_q;
        if ((state_q == ST_PWRUP) && timer_done && RAIL_INIT_ON[rail_idx_q]) begin
            rail_en_d[rail_idx_q] = 1'b1;
        end
        if (accept) begin
            rail_en_d[NUM_RAILS-1] = 1'b0;
            if (image_oor) begin
                bad_image_d = 1'b1;
            end
        end
        if ((state_q == ST_RAIL_DOWN) && timer_done && (rail_idx_q != '0)) begin
            rail_en_d[rail_idx_q - RAIL_IDX_W'(1)] = 1'b0;
        end
        if (abort_hit) begin
            rail_en_d = RAIL_INIT_ON;
        end
        pads_release_d = (state_d != ST_IDLE);
        busy_d         = (state_d != ST_IDLE);
        req_ready_d    = (state_d == ST_IDLE);
        wb_s_d         = ((state_d == ST_ARM) || (state_d == ST_BOOT)) ? image_d : '0;
        wb_boot_d      = (state_d == ST_BOOT);
    end

    assign rail_en      = rail_en_q;
    assign pads_release = pads_release_q;
    assign wb_s         = wb_s_q;
    assign wb_boot      = wb_boot_q;
    assign busy         = busy_q;
    assign req_ready    = req_ready_q;
    assign bad_image    = bad_image_q;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed bench: table-driven timing vectors plus hand-written reset,
// bad-image and idle-window sequences on a small-timing build.
module tb_warmboot_sequencer;

    logic       clk_48mhz = 1'b0;
    logic       reset_n   = 1'b0;

    logic       req_valid = 1'b0;
    logic [1:0] req_image = 2'd0;
    logic       abort     = 1'b0;
    logic       req_ready;
    logic [1:0] rail_en;
    logic       pads_release;
    logic [1:0] wb_s;
    logic       wb_boot;
    logic       busy;
    logic       bad_image;

    logic       req2_valid = 1'b0;
    logic [1:0] req2_image = 2'd0;
    logic       abort2     = 1'b0;
    logic       req2_ready;
    logic [1:0] rail2_en;
    logic       pads2_release;
    logic [1:0] wb2_s;
    logic       wb2_boot;
    logic       busy2;
    logic       bad2_image;

    int checks = 0;
    int errors = 0;

    always #5 clk_48mhz = ~clk_48mhz;

    warmboot_sequencer #(
        .NUM_RAILS(2), .RAIL_INIT_ON(2'b11), .RAIL_STEP(4),
        .SETTLE_CYCLES(8), .NUM_IMAGES(4)
    ) dut (
        .clk_48mhz(clk_48mhz), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_image(req_image),
        .abort(abort), .rail_en(rail_en), .pads_release(pads_release),
        .wb_s(wb_s), .wb_boot(wb_boot), .busy(busy), .bad_image(bad_image)
    );

    warmboot_sequencer #(
        .NUM_RAILS(2), .RAIL_INIT_ON(2'b11), .RAIL_STEP(4),
        .SETTLE_CYCLES(8), .NUM_IMAGES(2)
    ) dut2 (
        .clk_48mhz(clk_48mhz), .reset_n(reset_n),
        .req_valid(req2_valid), .req_ready(req2_ready), .req_image(req2_image),
        .abort(abort2), .rail_en(rail2_en), .pads_release(pads2_release),
        .wb_s(wb2_s), .wb_boot(wb2_boot), .busy(busy2), .bad_image(bad2_image)
    );

    typedef struct {
        int         seq;
        int         cyc;
        logic       abort;
        logic [1:0] rail_en;
        logic       pads;
        logic       ready;
        logic       busy;
        logic [1:0] wb_s;
        logic       wb_boot;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    // Holds reset across an edge and releases it just after the next one;
    // the caller is then in cycle 0 of power-up.
    task automatic pulse_reset();
        reset_n = 1'b0;
        @(posedge clk_48mhz);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_seq(input int s, input int first, input int last);
        for (int c = first; c <= last; c++) begin
            abort = 1'b0;
            foreach (vecs[i]) begin
                if (vecs[i].seq == s && vecs[i].cyc == c) begin
                    check($sformatf("s%0d c%0d rail_en", s, c), 32'(rail_en), 32'(vecs[i].rail_en));
                    check($sformatf("s%0d c%0d pads", s, c), 32'(pads_release), 32'(vecs[i].pads));
                    check($sformatf("s%0d c%0d ready", s, c), 32'(req_ready), 32'(vecs[i].ready));
                    check($sformatf("s%0d c%0d busy", s, c), 32'(busy), 32'(vecs[i].busy));
                    check($sformatf("s%0d c%0d wb_s", s, c), 32'(wb_s), 32'(vecs[i].wb_s));
                    check($sformatf("s%0d c%0d wb_boot", s, c), 32'(wb_boot), 32'(vecs[i].wb_boot));
                    abort = vecs[i].abort;
                end
            end
            if (c < last) tick();
        end
        abort = 1'b0;
    endtask

    initial begin
        logic boot_seen;

        // seq 0: power-up, cycle 0 is the first cycle after reset release
        vecs.push_back('{0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{0, 3, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{0, 4, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{0, 7, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{0, 8, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0});
        // seq 1: image 2 accepted at t, offsets relative to t
        vecs.push_back('{1, 1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{1, 4, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{1, 5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{1, 8, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{1, 16, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{1, 17, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0});
        vecs.push_back('{1, 18, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0});
        vecs.push_back('{1, 19, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1});
        vecs.push_back('{1, 25, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1});
        // seq 2: abort while the last rail is stepping down
        vecs.push_back('{2, 1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{2, 6, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{2, 7, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{2, 8, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0});
        // seq 3: abort during settle
        vecs.push_back('{3, 9, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{3, 12, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{3, 13, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{3, 14, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0});

        #1;
        check("reset bad_image", 32'(bad_image), 32'd0);
        check("reset wb_boot", 32'(wb_boot), 32'd0);
        @(posedge clk_48mhz);
        pulse_reset();
        run_seq(0, 0, 8);
        check("idle dut2 ready", 32'(req2_ready), 32'd1);

        // Image 2 on dut with req_valid held high throughout; dut2 gets image 3.
        req_image  = 2'd2;
        req_valid  = 1'b1;
        req2_image = 2'd3;
        req2_valid = 1'b1;
        check("dut2 bad before accept", 32'(bad2_image), 32'd0);
        tick();
        req2_valid = 1'b0;
        check("dut2 bad at t+1", 32'(bad2_image), 32'd1);
        check("dut2 busy at t+1", 32'(busy2), 32'd1);
        run_seq(1, 1, 25);
        req_valid = 1'b0;
        check("dut bad_image valid img", 32'(bad_image), 32'd0);
        check("dut2 wb_s oor image", 32'(wb2_s), 32'd0);
        check("dut2 wb_boot", 32'(wb2_boot), 32'd1);
        check("dut2 bad sticky", 32'(bad2_image), 32'd1);

        // Reset asserted while in BOOT drops wb_boot without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("rst in boot wb_boot", 32'(wb_boot), 32'd0);
        check("rst in boot wb_s", 32'(wb_s), 32'd0);
        check("rst in boot bad2", 32'(bad2_image), 32'd0);
        pulse_reset();
        run_seq(0, 0, 8);

        // Reset asserted during ARM.
        req_image = 2'd1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (16) tick();
        check("arm wb_s", 32'(wb_s), 32'd1);
        check("arm wb_boot", 32'(wb_boot), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst in arm wb_s", 32'(wb_s), 32'd0);
        check("rst in arm wb_boot", 32'(wb_boot), 32'd0);
        check("rst in arm rail_en", 32'(rail_en), 32'd0);
        check("rst in arm busy", 32'(busy), 32'd1);
        check("rst in arm pads", 32'(pads_release), 32'd1);
        check("rst in arm ready", 32'(req_ready), 32'd0);
        pulse_reset();
        run_seq(0, 0, 8);

        // Aborts: one in RAIL_DOWN, one in SETTLE.
        req_image = 2'd3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        run_seq(2, 1, 8);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        run_seq(3, 1, 14);
        boot_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (wb_boot) boot_seen = 1'b1;
        end
        check("no boot after abort", 32'(boot_seen), 32'd0);
        check("idle ready after abort", 32'(req_ready), 32'd1);
        check("bad_image after abort", 32'(bad_image), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
